controle_cancela: RTL and testbench
===================================

Name: controle_cancela

Overview:
- Gate (cancela) controller FSM for the vehicle access system.
- Consumer and driver side of the 20 s timer interface: drives the timer's enable (on_off) and restart (rest), and consumes its tempo_20s end-of-count strobe.
- Sequences the barrier motor from an access-granted request, limit switches and the passage sensor.
- Adds motor-travel supervision with a fault state.

Parameters:
- T_MOTOR, 8: max clk cycles allowed for a full open or close travel before fault.
- W_MOTOR, 4: width of the travel counter; must satisfy 2^W_MOTOR > T_MOTOR.

Ports:
- clk  input  1  system tick (1 Hz in this design, same clock as the timer).
- rest  input  1  reset, asynchronous, active-high.
- acesso_ok  input  1  access granted (tag/password validated), level, sampled on clk.
- sensor_passagem  input  1  vehicle present under barrier.
- fim_aberta  input  1  open limit switch.
- fim_fechada  input  1  closed limit switch.
- limpa_falha  input  1  operator fault acknowledge.
- tempo_20s  input  1  end-of-20 s strobe from the timer.
- timer_on  output  1  timer enable, to timer on_off.
- timer_rest  output  1  timer restart pulse, to timer rest.
- motor_abrir  output  1  drive barrier open.
- motor_fechar  output  1  drive barrier closed.
- luz_verde  output  1  green lamp.
- luz_vermelha  output  1  red lamp.
- alarme  output  1  fault indicator.
- n_veiculos  output  8  passage counter (see Optional Feature).

Behaviour:
- Clocking: one clock clk; reset rest is asynchronous and active-high.
- Reset: state FECHADA, travel counter 0, timer_rest 0, n_veiculos 0.
- Output decode (Moore, from the state register):
  - FECHADA: luz_vermelha=1.
  - ABRINDO: motor_abrir=1, luz_vermelha=1.
  - ABERTA: luz_verde=1, timer_on=1.
  - FECHANDO: motor_fechar=1, luz_vermelha=1.
  - FALHA: alarme=1, luz_vermelha=1.
  - All other outputs are 0. motor_abrir and motor_fechar are never both 1.
- Transitions: one clk latency from the sampled input to the new state and outputs.
  - FECHADA: acesso_ok=1 -> ABRINDO. Otherwise hold.
  - ABRINDO:
    - fim_aberta=1 -> ABERTA.
    - Otherwise, travel counter == T_MOTOR-1 -> FALHA.
    - Otherwise, counter+1.
  - ABERTA:
    - tempo_20s=1 and sensor_passagem=0 -> FECHANDO.
    - sensor_passagem=1 or acesso_ok=1 -> stay; timer_rest=1 for exactly the next cycle, which restarts the 20 s window.
    - tempo_20s=1 with sensor_passagem=1 -> stay plus timer_rest pulse.
  - FECHANDO:
    - sensor_passagem=1 or acesso_ok=1 -> ABRINDO (safety reversal; counter reloaded to 0).
    - Otherwise, fim_fechada=1 -> FECHADA.
    - Otherwise, timeout at T_MOTOR-1 -> FALHA.
  - FALHA: limpa_falha=1 -> FECHADA if fim_fechada=1, else FECHANDO (counter 0). Only rest or limpa_falha leave FALHA.
- Travel counter: cleared on every entry to ABRINDO/FECHANDO; saturates and never wraps.
- timer_on falls on leaving ABERTA; the timer clears on that edge. Its count restarts from 0 on the next entry.
- Priorities and boundaries:
  - fim_aberta and fim_fechada both 1 while in ABRINDO or FECHANDO -> FALHA (sensor fault).
  - Limit switch and timeout in the same cycle -> limit switch wins.
  - In FECHANDO, the sensor beats fim_fechada.
  - tempo_20s outside ABERTA is ignored.
  - rest mid-motion forces FECHADA immediately with the motors off. The barrier is then not re-driven until acesso_ok.

Optional Feature:
- Macro: CONTADOR_VEICULOS_EN.
- Defined: n_veiculos increments on each falling edge of sensor_passagem, detected while in ABERTA. sensor_passagem is registered one cycle for edge detection. The count wraps 255->0 and is cleared by rest.
- Undefined: the port exists and is tied to 0; no edge register.

Test Plan:
- Reset, then acesso_ok=1 for 1 cycle -> ABRINDO: motor_abrir=1 next cycle. fim_aberta=1 at cycle 3 -> luz_verde=1, timer_on=1.
- ABERTA, sensor_passagem=0, tempo_20s pulsed -> next cycle motor_fechar=1, timer_on=0. fim_fechada=1 -> FECHADA, luz_vermelha=1.
- ABERTA, sensor_passagem=1 when tempo_20s=1 -> stays ABERTA, timer_rest=1 for one cycle. Sensor drops, next tempo_20s -> FECHANDO.
- FECHANDO, sensor_passagem=1 -> motor_abrir=1 next cycle, counter 0. Same cycle as fim_fechada=1 -> still ABRINDO.
- ABRINDO with no fim_aberta for 8 cycles (T_MOTOR=8) -> alarme=1, motors 0. limpa_falha with fim_fechada=0 -> FECHANDO.
- With CONTADOR_VEICULOS_EN: 3 sensor pulses in ABERTA -> n_veiculos=3. rest asserted mid-ABRINDO -> all outputs at reset values asynchronously, n_veiculos=0.

Source files
------------

// File: rtl/controle_cancela_if.sv
// rtl/controle_cancela_if.sv - link between the gate controller and the 20 s timer
interface controle_cancela_if;
   logic timer_on;
   logic timer_rest;
   logic tempo_20s;

   modport master (output timer_on, output timer_rest, input tempo_20s);
   modport slave  (input timer_on, input timer_rest, output tempo_20s);
endinterface

// File: rtl/controle_cancela.sv
// rtl/controle_cancela.sv - barrier FSM with travel supervision; CONTADOR_VEICULOS_EN enables the passage counter
module controle_cancela #(
   parameter int T_MOTOR = 8,
   parameter int W_MOTOR = 4
) (
   input  logic                clk,
   input  logic                rest,
   input  logic                acesso_ok,
   input  logic                sensor_passagem,
   input  logic                fim_aberta,
   input  logic                fim_fechada,
   input  logic                limpa_falha,
   controle_cancela_if.master  tmr,
   output logic                motor_abrir,
   output logic                motor_fechar,
   output logic                luz_verde,
   output logic                luz_vermelha,
   output logic                alarme,
   output logic [7:0]          n_veiculos
);

   typedef enum logic [2:0] {
      FECHADA  = 3'd0,
      ABRINDO  = 3'd1,
      ABERTA   = 3'd2,
      FECHANDO = 3'd3,
      FALHA    = 3'd4
   } estado_t;

   localparam logic [W_MOTOR-1:0] CNT_LIM = W_MOTOR'(T_MOTOR - 1);

   estado_t              estado, prox;
   logic [W_MOTOR-1:0]   cnt, prox_cnt;
   logic                 pede_rest;

   always_comb begin
      prox      = estado;
      prox_cnt  = cnt;
      pede_rest = 1'b0;
      case (estado)
         FECHADA: begin
            if (acesso_ok) begin
               prox     = ABRINDO;
               prox_cnt = '0;
            end
         end
         ABRINDO: begin
            if (fim_aberta && fim_fechada)
               prox = FALHA;
            else if (fim_aberta)
               prox = ABERTA;
            else if (cnt == CNT_LIM)
               prox = FALHA;
            else if (cnt != '1)
               prox_cnt = cnt + 1'b1;
         end
         ABERTA: begin
            // A vehicle or a fresh grant keeps the gate open and restarts the window
            if (sensor_passagem || acesso_ok)
               pede_rest = 1'b1;
            else if (tmr.tempo_20s) begin
               prox     = FECHANDO;
               prox_cnt = '0;
            end
         end
         FECHANDO: begin
            if (fim_aberta && fim_fechada)
               prox = FALHA;
            else if (sensor_passagem || acesso_ok) begin
               prox     = ABRINDO;
               prox_cnt = '0;
            end else if (fim_fechada)
               prox = FECHADA;
            else if (cnt == CNT_LIM)
               prox = FALHA;
            else if (cnt != '1)
               prox_cnt = cnt + 1'b1;
         end
         FALHA: begin
            if (limpa_falha) begin
               prox     = fim_fechada ? FECHADA : FECHANDO;
               prox_cnt = '0;
            end
         end
         default: begin
            prox     = FECHADA;
            prox_cnt = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so they change together with it
   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         estado         <= FECHADA;
         cnt            <= '0;
         tmr.timer_rest <= 1'b0;
         tmr.timer_on   <= 1'b0;
         motor_abrir    <= 1'b0;
         motor_fechar   <= 1'b0;
         luz_verde      <= 1'b0;
         luz_vermelha   <= 1'b1;
         alarme         <= 1'b0;
      end else begin
         estado         <= prox;
         cnt            <= prox_cnt;
         tmr.timer_rest <= pede_rest;
         tmr.timer_on   <= (prox == ABERTA);
         motor_abrir    <= (prox == ABRINDO);
         motor_fechar   <= (prox == FECHANDO);
         luz_verde      <= (prox == ABERTA);
         luz_vermelha   <= (prox != ABERTA);
         alarme         <= (prox == FALHA);
      end
   end

`ifdef CONTADOR_VEICULOS_EN
   logic       sensor_q;
   logic [7:0] contagem;

   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         sensor_q <= 1'b0;
         contagem <= 8'd0;
      end else begin
         sensor_q <= sensor_passagem;
         if (estado == ABERTA && sensor_q && !sensor_passagem)
            contagem <= contagem + 8'd1;
      end
   end

   assign n_veiculos = contagem;
`else
   assign n_veiculos = 8'd0;
`endif

endmodule

// File: tb/tb_controle_cancela.sv
// tb/tb_controle_cancela.sv - directed self-checking bench for controle_cancela
module tb_controle_cancela;

   logic clk = 1'b0;
   logic rest = 1'b0;
   logic acesso_ok = 1'b0;
   logic sensor_passagem = 1'b0;
   logic fim_aberta = 1'b0;
   logic fim_fechada = 1'b0;
   logic limpa_falha = 1'b0;
   logic motor_abrir, motor_fechar, luz_verde, luz_vermelha, alarme;
   logic [7:0] n_veiculos;

   int checks = 0;
   int failures = 0;
   int n_exp = 0;

   // {timer_on, timer_rest, motor_abrir, motor_fechar, luz_verde, luz_vermelha, alarme}
   localparam logic [6:0] O_FECHADA  = 7'b0000010;
   localparam logic [6:0] O_ABRINDO  = 7'b0010010;
   localparam logic [6:0] O_ABERTA   = 7'b1000100;
   localparam logic [6:0] O_ABERTA_R = 7'b1100100;
   localparam logic [6:0] O_FECHANDO = 7'b0001010;
   localparam logic [6:0] O_FALHA    = 7'b0000011;

   controle_cancela_if tmr ();

   controle_cancela #(.T_MOTOR(8), .W_MOTOR(4)) dut (
      .clk             (clk),
      .rest            (rest),
      .acesso_ok       (acesso_ok),
      .sensor_passagem (sensor_passagem),
      .fim_aberta      (fim_aberta),
      .fim_fechada     (fim_fechada),
      .limpa_falha     (limpa_falha),
      .tmr             (tmr.master),
      .motor_abrir     (motor_abrir),
      .motor_fechar    (motor_fechar),
      .luz_verde       (luz_verde),
      .luz_vermelha    (luz_vermelha),
      .alarme          (alarme),
      .n_veiculos      (n_veiculos)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [6:0] exp);
      logic [6:0] obs;
      obs = {tmr.timer_on, tmr.timer_rest, motor_abrir, motor_fechar,
             luz_verde, luz_vermelha, alarme};
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_cnt(input string tag);
      logic [7:0] exp;
`ifdef CONTADOR_VEICULOS_EN
      exp = 8'(n_exp);
`else
      exp = 8'd0;
`endif
      checks++;
      assert (n_veiculos === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, n_veiculos, exp);
      end
   endtask

   initial begin
      tmr.tempo_20s = 1'b0;
      rest = 1'b1;
      #1;
      chk_out("reset_outputs", O_FECHADA);
      chk_cnt("reset_count");
      step();
      rest = 1'b0;
      step();
      chk_out("idle_hold", O_FECHADA);

      // open
      acesso_ok = 1'b1;
      step();
      acesso_ok = 1'b0;
      chk_out("abrindo", O_ABRINDO);
      step();
      fim_aberta = 1'b1;
      step();
      fim_aberta = 1'b0;
      chk_out("aberta", O_ABERTA);

      // tempo_20s with no vehicle closes
      tmr.tempo_20s = 1'b1;
      step();
      tmr.tempo_20s = 1'b0;
      chk_out("fechando", O_FECHANDO);
      fim_fechada = 1'b1;
      step();
      fim_fechada = 1'b0;
      chk_out("fechada", O_FECHADA);

      // vehicle under barrier at end of window
      acesso_ok = 1'b1;
      step();
      acesso_ok = 1'b0;
      fim_aberta = 1'b1;
      step();
      fim_aberta = 1'b0;
      sensor_passagem = 1'b1;
      tmr.tempo_20s = 1'b1;
      step();
      tmr.tempo_20s = 1'b0;
      sensor_passagem = 1'b0;
      chk_out("aberta_rest_pulse", O_ABERTA_R);
      step();
      n_exp++;
      chk_out("aberta_rest_drop", O_ABERTA);
      tmr.tempo_20s = 1'b1;
      step();
      tmr.tempo_20s = 1'b0;
      chk_out("fechando_2", O_FECHANDO);

      // safety reversal beats the closed limit switch
      sensor_passagem = 1'b1;
      fim_fechada = 1'b1;
      step();
      sensor_passagem = 1'b0;
      fim_fechada = 1'b0;
      chk_out("reversal", O_ABRINDO);

      // travel timeout after 8 cycles in ABRINDO
      for (int i = 0; i < 7; i++) begin
         step();
         chk_out($sformatf("abrindo_wait_%0d", i), O_ABRINDO);
      end
      step();
      chk_out("timeout_falha", O_FALHA);
      tmr.tempo_20s = 1'b1;
      acesso_ok = 1'b1;
      step();
      step();
      tmr.tempo_20s = 1'b0;
      acesso_ok = 1'b0;
      chk_out("falha_hold", O_FALHA);
      limpa_falha = 1'b1;
      step();
      limpa_falha = 1'b0;
      chk_out("clear_to_fechando", O_FECHANDO);

      // both limit switches is a sensor fault
      fim_aberta = 1'b1;
      fim_fechada = 1'b1;
      step();
      fim_aberta = 1'b0;
      chk_out("dual_switch_falha", O_FALHA);
      limpa_falha = 1'b1;
      step();
      limpa_falha = 1'b0;
      fim_fechada = 1'b0;
      chk_out("clear_to_fechada", O_FECHADA);

      // limit switch wins over timeout on the last travel cycle
      acesso_ok = 1'b1;
      step();
      acesso_ok = 1'b0;
      for (int i = 0; i < 7; i++) step();
      chk_out("abrindo_last_cycle", O_ABRINDO);
      fim_aberta = 1'b1;
      step();
      fim_aberta = 1'b0;
      chk_out("limit_beats_timeout", O_ABERTA);

      // three more passages
      for (int i = 0; i < 3; i++) begin
         sensor_passagem = 1'b1;
         step();
         sensor_passagem = 1'b0;
         step();
         n_exp++;
      end
      chk_cnt("passage_count");
      chk_out("aberta_after_passages", O_ABERTA);

      // reversal then asynchronous reset mid-travel
      tmr.tempo_20s = 1'b1;
      step();
      tmr.tempo_20s = 1'b0;
      acesso_ok = 1'b1;
      step();
      acesso_ok = 1'b0;
      chk_out("reversal_grant", O_ABRINDO);
      step();
      #2;
      rest = 1'b1;
      #1;
      n_exp = 0;
      chk_out("async_reset_outputs", O_FECHADA);
      chk_cnt("async_reset_count");
      step();
      rest = 1'b0;
      step();
      step();
      chk_out("no_redrive_after_reset", O_FECHADA);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
